// File: rtl/sram_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: request payload and port identifiers.
package sram_arb_pkg;

  localparam int unsigned SRAM_BITS = 32;
  localparam int unsigned SRAM_AW   = 5;

  typedef struct packed {
    logic                 wen;
    logic [SRAM_AW-1:0]   adress;
    logic [SRAM_BITS-1:0] din;
    logic [SRAM_BITS-1:0] mask;
  } sram_req_t;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_LSU   = 1'b1
  } port_id_t;

endpackage

// File: rtl/sram_arb2_arb_rr2.sv
// 2-way grant logic with last_grant history.
// SRAM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module arb_rr2
  import sram_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     valid0,
  input  logic     valid1,
  output logic     gnt0,
  output logic     gnt1
);

`ifdef SRAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  port_id_t last_grant;
  logic     pri0;

  // Port 0 wins a conflict unless round-robin says it was served last.
  always_comb begin
    pri0 = 1'b1;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (RR_EN) pri0 = (last_grant == PORT_LSU);
    if (!rst) begin
      gnt0 = valid0 && (!valid1 || pri0);
      gnt1 = valid1 && !gnt0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT_LSU;
    end else if (gnt0 || gnt1) begin
      last_grant <= gnt1 ? PORT_LSU : PORT_FETCH;
    end
  end

endmodule

// File: rtl/sram_arb2.sv
// Two-port arbiter/sequencer in front of a single-port SRAM with 1-cycle read.
// Arbitration policy selected by SRAM_ARB_RR_EN (see arb_rr2).
module sram_arb2
  import sram_arb_pkg::*;
#(
  parameter int unsigned BITS         = 32,
  parameter int unsigned ADRESS_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    p0_req_valid,
  output logic                    p0_req_ready,
  input  logic                    p0_req_wen,
  input  logic [ADRESS_WIDTH-1:0] p0_req_adress,
  input  logic [BITS-1:0]         p0_req_din,
  input  logic [BITS-1:0]         p0_req_mask,
  output logic                    p0_rsp_valid,
  output logic [BITS-1:0]         p0_rsp_data,
  input  logic                    p1_req_valid,
  output logic                    p1_req_ready,
  input  logic                    p1_req_wen,
  input  logic [ADRESS_WIDTH-1:0] p1_req_adress,
  input  logic [BITS-1:0]         p1_req_din,
  input  logic [BITS-1:0]         p1_req_mask,
  output logic                    p1_rsp_valid,
  output logic [BITS-1:0]         p1_rsp_data,
  output logic                    sram_cen,
  output logic                    sram_wen,
  output logic [ADRESS_WIDTH-1:0] sram_adress,
  output logic [BITS-1:0]         sram_din,
  output logic [BITS-1:0]         sram_mask,
  input  logic [BITS-1:0]         sram_dout
);

  logic      gnt0, gnt1;
  sram_req_t req0, req1, req_sel;
  logic      pend_vld;
  port_id_t  pend_port;

  arb_rr2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid0 (p0_req_valid),
    .valid1 (p1_req_valid),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  assign p0_req_ready = gnt0;
  assign p1_req_ready = gnt1;

  assign req0 = '{wen: p0_req_wen, adress: SRAM_AW'(p0_req_adress),
                  din: SRAM_BITS'(p0_req_din), mask: SRAM_BITS'(p0_req_mask)};
  assign req1 = '{wen: p1_req_wen, adress: SRAM_AW'(p1_req_adress),
                  din: SRAM_BITS'(p1_req_din), mask: SRAM_BITS'(p1_req_mask)};

  // Idle cycles drive all SRAM pins to zero.
  always_comb begin
    req_sel = '0;
    if (gnt1)      req_sel = req1;
    else if (gnt0) req_sel = req0;
  end

  assign sram_cen    = gnt0 | gnt1;
  assign sram_wen    = req_sel.wen;
  assign sram_adress = ADRESS_WIDTH'(req_sel.adress);
  assign sram_din    = BITS'(req_sel.din);
  assign sram_mask   = BITS'(req_sel.mask);

  // Track the port owed read data on the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld  <= 1'b0;
      pend_port <= PORT_FETCH;
    end else begin
      pend_vld <= (gnt0 && !p0_req_wen) || (gnt1 && !p1_req_wen);
      if (gnt0 || gnt1) pend_port <= gnt1 ? PORT_LSU : PORT_FETCH;
    end
  end

  // Response in a reset cycle is dropped.
  always_comb begin
    p0_rsp_valid = pend_vld && !rst && (pend_port == PORT_FETCH);
    p1_rsp_valid = pend_vld && !rst && (pend_port == PORT_LSU);
    p0_rsp_data  = p0_rsp_valid ? sram_dout : '0;
    p1_rsp_data  = p1_rsp_valid ? sram_dout : '0;
  end

endmodule

// File: tb/tb_sram_arb2.sv
// Directed table-driven bench for sram_arb2 with a behavioural masked-write SRAM.
module tb_sram_arb2;

  logic        clk, rst;
  logic        p0_req_valid, p0_req_ready, p0_req_wen, p0_rsp_valid;
  logic [4:0]  p0_req_adress;
  logic [31:0] p0_req_din, p0_req_mask, p0_rsp_data;
  logic        p1_req_valid, p1_req_ready, p1_req_wen, p1_rsp_valid;
  logic [4:0]  p1_req_adress;
  logic [31:0] p1_req_din, p1_req_mask, p1_rsp_data;
  logic        sram_cen, sram_wen;
  logic [4:0]  sram_adress;
  logic [31:0] sram_din, sram_mask, sram_dout;

  logic [31:0] mem [32];
  int          n_tests, n_fail;

  sram_arb2 dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_wen(p0_req_wen),
    .p0_req_adress(p0_req_adress), .p0_req_din(p0_req_din), .p0_req_mask(p0_req_mask),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_data(p0_rsp_data),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_wen(p1_req_wen),
    .p1_req_adress(p1_req_adress), .p1_req_din(p1_req_din), .p1_req_mask(p1_req_mask),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_data(p1_rsp_data),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_adress(sram_adress),
    .sram_din(sram_din), .sram_mask(sram_mask), .sram_dout(sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: mask bit 1 keeps the old bit, registered read.
  always @(posedge clk) begin
    if (sram_cen) begin
      if (sram_wen) mem[sram_adress] <= (mem[sram_adress] & sram_mask) | (sram_din & ~sram_mask);
      else          sram_dout <= mem[sram_adress];
    end
  end

  typedef struct {
    logic v0, w0; logic [4:0] a0; logic [31:0] d0, m0;
    logic v1, w1; logic [4:0] a1; logic [31:0] d1, m1;
    logic r0, r1, cen, wen; logic [4:0] addr;
    logic rv0, rv1; logic [31:0] rd0, rd1;
  } vec_t;

  vec_t vecs [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, w0, input logic [4:0] a0, input logic [31:0] d0, m0,
                       input logic v1, w1, input logic [4:0] a1, input logic [31:0] d1, m1);
    p0_req_valid = v0; p0_req_wen = w0; p0_req_adress = a0; p0_req_din = d0; p0_req_mask = m0;
    p1_req_valid = v1; p1_req_wen = w1; p1_req_adress = a1; p1_req_din = d1; p1_req_mask = m1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] snap();
    return 128'({p0_req_ready, p1_req_ready, sram_cen, sram_wen, sram_adress,
                 p0_rsp_valid, p1_rsp_valid, p0_rsp_data, p1_rsp_data});
  endfunction

  initial begin
    logic rr, g, pg;
    logic [127:0] exp;
`ifdef SRAM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    n_tests = 0; n_fail = 0;
    sram_dout = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    //          v0 w0 a0  d0            m0             v1 w1 a1  d1            m1             r0 r1 ce we ad rv0 rv1 rd0           rd1
    vecs[0]  = '{0, 0, 0, 32'h0,        32'h0,         0, 0, 0, 32'h0,        32'h0,         0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0};
    vecs[1]  = '{1, 1, 3, 32'hDEADBEEF, 32'h0,         0, 0, 0, 32'h0,        32'h0,         1, 0, 1, 1, 3, 0, 0, 32'h0,        32'h0};
    vecs[2]  = '{1, 0, 3, 32'h0,        32'h0,         0, 0, 0, 32'h0,        32'h0,         1, 0, 1, 0, 3, 0, 0, 32'h0,        32'h0};
    vecs[3]  = '{0, 0, 0, 32'h0,        32'h0,         0, 0, 0, 32'h0,        32'h0,         0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 32'h0};
    vecs[4]  = '{0, 0, 0, 32'h0,        32'h0,         1, 1, 5, 32'h12345678, 32'h0,         0, 1, 1, 1, 5, 0, 0, 32'h0,        32'h0};
    vecs[5]  = '{0, 0, 0, 32'h0,        32'h0,         1, 1, 5, 32'hAAAAAAAA, 32'hFFFF0000,  0, 1, 1, 1, 5, 0, 0, 32'h0,        32'h0};
    vecs[6]  = '{0, 0, 0, 32'h0,        32'h0,         1, 0, 5, 32'h0,        32'h0,         0, 1, 1, 0, 5, 0, 0, 32'h0,        32'h0};
    vecs[7]  = '{1, 1, 5, 32'h0,        32'hFFFFFFFF,  0, 0, 0, 32'h0,        32'h0,         1, 0, 1, 1, 5, 0, 1, 32'h0,        32'h1234AAAA};
    vecs[8]  = '{1, 0, 5, 32'h0,        32'h0,         0, 0, 0, 32'h0,        32'h0,         1, 0, 1, 0, 5, 0, 0, 32'h0,        32'h0};
    vecs[9]  = '{0, 0, 0, 32'h0,        32'h0,         1, 0, 3, 32'h0,        32'h0,         0, 1, 1, 0, 3, 1, 0, 32'h1234AAAA, 32'h0};
    vecs[10] = '{0, 0, 0, 32'h0,        32'h0,         0, 0, 0, 32'h0,        32'h0,         0, 0, 0, 0, 0, 0, 1, 32'h0,        32'hDEADBEEF};
    vecs[11] = '{0, 0, 0, 32'h0,        32'h0,         0, 0, 0, 32'h0,        32'h0,         0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0};

    // Reset: ready must stay low even with a valid request.
    rst = 1'b1;
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step();
    @(negedge clk);
    chk("reset_state", snap(), 128'h0);
    step();
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].v0, vecs[i].w0, vecs[i].a0, vecs[i].d0, vecs[i].m0,
            vecs[i].v1, vecs[i].w1, vecs[i].a1, vecs[i].d1, vecs[i].m1);
      @(negedge clk);
      exp = 128'({vecs[i].r0, vecs[i].r1, vecs[i].cen, vecs[i].wen, vecs[i].addr,
                  vecs[i].rv0, vecs[i].rv1, vecs[i].rd0, vecs[i].rd1});
      chk($sformatf("vec%0d", i), snap(), exp);
      step();
    end

    // Preload addr 1 / addr 2 for the contention run, then reset the arbiter.
    drive(1, 1, 1, 32'h11111111, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 1, 2, 32'h22222222, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; step(); rst = 1'b0;

    // Continuous reads from both ports.
    pg = 1'b0;
    drive(1, 0, 1, 0, 0, 1, 0, 2, 0, 0);
    for (int k = 0; k < 6; k++) begin
      g = rr ? k[0] : 1'b0;
      @(negedge clk);
      chk($sformatf("contend_rdy%0d", k), 128'({p0_req_ready, p1_req_ready}), 128'({!g, g}));
      if (k > 0)
        chk($sformatf("contend_rsp%0d", k),
            128'({p0_rsp_valid, p1_rsp_valid, p0_rsp_data, p1_rsp_data}),
            128'({!pg, pg, pg ? 32'h0 : 32'h11111111, pg ? 32'h22222222 : 32'h0}));
      pg = g;
      step();
    end

    // Read granted, then reset the following cycle: response dropped.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    drive(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_seq_grant", 128'({p0_req_ready, sram_cen}), 128'({1'b1, 1'b1}));
    step();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0, 2, 0, 0);
    @(negedge clk);
    chk("rst_seq_in_reset", 128'({p1_req_ready, sram_cen, p0_rsp_valid, p1_rsp_valid}), 128'h0);
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_seq_after", 128'({p0_rsp_valid, p1_rsp_valid, sram_cen, sram_adress}), 128'h0);
    step();
    drive(1, 0, 1, 0, 0, 1, 0, 2, 0, 0);
    @(negedge clk);
    chk("rst_first_conflict", 128'({p0_req_ready, p1_req_ready}), 128'({1'b1, 1'b0}));
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_conflict_rsp", 128'({p0_rsp_valid, p1_rsp_valid, p0_rsp_data}),
        128'({1'b1, 1'b0, 32'h11111111}));
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
